// File: rtl/mem_stage_param.sv
// Data-memory pipeline stage: byte-addressed little-endian word memory with
// RISC-V load/store sizing, registered results, per-access fault flags and a
// self-clearing start-up sequence that zeroes every word after reset.
module mem_stage_param #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned DEPTH = 1024
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Valid,
  input  logic [XLEN-1:0] ALUResult,
  input  logic [XLEN-1:0] WriteData,
  input  logic [2:0]      Funct3,
  input  logic [4:0]      Rd,
  input  logic            Zero,
  input  logic            BranchTaken,
  input  logic            MemRead,
  input  logic            MemWrite,
  input  logic            MemtoReg,
  input  logic            RegWrite,
  output logic [XLEN-1:0] ReadData,
  output logic [XLEN-1:0] ALUResultOut,
  output logic [4:0]      RdOut,
  output logic            BranchTakenOut,
  output logic            MemtoRegOut,
  output logic            RegWriteOut,
  output logic            ValidOut,
  output logic            Busy,
  output logic            Misaligned,
  output logic            OutOfBounds,
  output logic            AccessFault
);

  localparam int unsigned NB  = XLEN / 8;
  localparam int unsigned OFF = $clog2(NB);
  localparam int unsigned AW  = $clog2(DEPTH);

  typedef enum logic [0:0] {StClear, StRun} state_t;

  state_t            r_state, w_state_d;
  logic [AW-1:0]     r_ptr, w_ptr_d;
  logic [XLEN-1:0]   r_mem [DEPTH];

  logic [XLEN-1:0]   r_read_data;
  logic [XLEN-1:0]   r_alu;
  logic [4:0]        r_rd;
  logic              r_bt, r_m2r, r_rw, r_valid;
  logic              r_ma, r_oob, r_af;

  logic              w_busy;
  logic [AW-1:0]     w_idx;
  logic [OFF-1:0]    w_boff;
  logic [1:0]        w_sz;
  logic              w_access;
  logic              w_af_raw, w_ma_raw, w_oob_raw;
  logic              w_af, w_ma, w_oob, w_fault;
  logic              w_load_ok, w_store_ok;
  logic [XLEN-1:0]   w_rword, w_shift, w_ext, w_rdata_d;
  logic [XLEN-1:0]   w_sdata, w_wmerge;
  logic [NB-1:0]     w_lane;
  logic              w_unused_zero;

  // Zero flag is carried on the interface but has no role in this stage.
  assign w_unused_zero = Zero;

  assign w_busy = (r_state == StClear);
  assign w_idx  = ALUResult[OFF+AW-1:OFF];
  assign w_boff = ALUResult[OFF-1:0];
  assign w_sz   = Funct3[1:0];

  // Only real memory operations are subject to fault checks.
  assign w_access = Valid & (MemRead | MemWrite) & ~w_busy;

  // Decode fault conditions from size code and address.
  always_comb begin
    w_af_raw = (Funct3 == 3'b111) | (MemWrite & Funct3[2]) |
               ((XLEN == 32) & ((Funct3 == 3'b011) | (Funct3 == 3'b110)));
    w_ma_raw = 1'b0;
    unique case (w_sz)
      2'd0: w_ma_raw = 1'b0;
      2'd1: w_ma_raw = ALUResult[0];
      2'd2: w_ma_raw = |ALUResult[1:0];
      2'd3: w_ma_raw = |ALUResult[2:0];
      default: w_ma_raw = 1'b0;
    endcase
    // Any address bit above the word index range puts the access out of bounds.
    w_oob_raw = |ALUResult[XLEN-1:OFF+AW];
  end

  // Single reported flag, AccessFault over Misaligned over OutOfBounds.
  assign w_af    = w_access & w_af_raw;
  assign w_ma    = w_access & ~w_af_raw & w_ma_raw;
  assign w_oob   = w_access & ~w_af_raw & ~w_ma_raw & w_oob_raw;
  assign w_fault = w_af | w_ma | w_oob;

  // A combined read+write is treated as a store with no load result.
  assign w_load_ok  = w_access & MemRead & ~MemWrite & ~w_fault;
  assign w_store_ok = w_access & MemWrite & ~w_fault;

  assign w_rword = r_mem[w_idx];
  assign w_shift = w_rword >> {w_boff, 3'b000};

  // Size and sign/zero extension of the selected load lanes.
  always_comb begin
    w_ext = '0;
    unique case (Funct3)
      3'b000:  w_ext = XLEN'($signed(w_shift[7:0]));
      3'b001:  w_ext = XLEN'($signed(w_shift[15:0]));
      3'b010:  w_ext = XLEN'($signed(w_shift[31:0]));
      3'b011:  w_ext = w_shift;
      3'b100:  w_ext = XLEN'(w_shift[7:0]);
      3'b101:  w_ext = XLEN'(w_shift[15:0]);
      3'b110:  w_ext = XLEN'(w_shift[31:0]);
      default: w_ext = '0;
    endcase
    w_rdata_d = w_load_ok ? w_ext : '0;
  end

  assign w_sdata = WriteData << {w_boff, 3'b000};

  // Byte-lane merge so a store only touches the addressed bytes.
  always_comb begin
    w_lane   = '0;
    w_wmerge = '0;
    for (int b = 0; b < int'(NB); b++) begin
      w_lane[b] = (b >= int'(w_boff)) && (b < int'(w_boff) + (1 << w_sz));
      w_wmerge[b*8 +: 8] = w_lane[b] ? w_sdata[b*8 +: 8] : w_rword[b*8 +: 8];
    end
  end

  // Memory array: zero-fill while clearing, otherwise accept legal stores.
  always_ff @(posedge clk) begin
    if (w_busy) begin
      r_mem[r_ptr] <= '0;
    end else if (w_store_ok) begin
      r_mem[w_idx] <= w_wmerge;
    end
  end

  // Clear/run state and clear pointer register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StClear;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_d;
      r_ptr   <= w_ptr_d;
    end
  end

  // Walk the pointer across every word, then hand over to normal operation.
  always_comb begin
    w_state_d = r_state;
    w_ptr_d   = r_ptr;
    unique case (r_state)
      StClear: begin
        w_ptr_d = r_ptr + 1'b1;
        if (r_ptr == AW'(DEPTH - 1)) begin
          w_state_d = StRun;
        end
      end
      StRun:   w_state_d = StRun;
      default: w_state_d = StClear;
    endcase
  end

  // Registered results; everything held at zero while clearing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_read_data <= '0;
      r_alu       <= '0;
      r_rd        <= '0;
      r_bt        <= 1'b0;
      r_m2r       <= 1'b0;
      r_rw        <= 1'b0;
      r_valid     <= 1'b0;
      r_ma        <= 1'b0;
      r_oob       <= 1'b0;
      r_af        <= 1'b0;
    end else if (w_busy) begin
      r_read_data <= '0;
      r_alu       <= '0;
      r_rd        <= '0;
      r_bt        <= 1'b0;
      r_m2r       <= 1'b0;
      r_rw        <= 1'b0;
      r_valid     <= 1'b0;
      r_ma        <= 1'b0;
      r_oob       <= 1'b0;
      r_af        <= 1'b0;
    end else begin
      r_read_data <= w_rdata_d;
      r_alu       <= ALUResult;
      r_rd        <= Rd;
      r_bt        <= BranchTaken;
      r_m2r       <= MemtoReg;
      r_rw        <= RegWrite;
      r_valid     <= Valid;
      r_ma        <= w_ma;
      r_oob       <= w_oob;
      r_af        <= w_af;
    end
  end

  assign ReadData       = r_read_data;
  assign ALUResultOut   = r_alu;
  assign RdOut          = r_rd;
  assign BranchTakenOut = r_bt;
  assign MemtoRegOut    = r_m2r;
  assign RegWriteOut    = r_rw;
  assign ValidOut       = r_valid;
  assign Busy           = w_busy;
  assign Misaligned     = r_ma;
  assign OutOfBounds    = r_oob;
  assign AccessFault    = r_af;

endmodule

// File: tb/tb_mem_stage_param.sv
// Bench for mem_stage_param (XLEN=64, DEPTH=1024): clear sequencing, directed
// vector table, reset corner cases and randomized traffic against a
// byte-array reference model.
module tb_mem_stage_param;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned DEPTH = 1024;
  localparam int unsigned BYTES = DEPTH * 8;

  logic            clk;
  logic            reset;
  logic            Valid;
  logic [XLEN-1:0] ALUResult;
  logic [XLEN-1:0] WriteData;
  logic [2:0]      Funct3;
  logic [4:0]      Rd;
  logic            Zero;
  logic            BranchTaken;
  logic            MemRead;
  logic            MemWrite;
  logic            MemtoReg;
  logic            RegWrite;
  logic [XLEN-1:0] ReadData;
  logic [XLEN-1:0] ALUResultOut;
  logic [4:0]      RdOut;
  logic            BranchTakenOut;
  logic            MemtoRegOut;
  logic            RegWriteOut;
  logic            ValidOut;
  logic            Busy;
  logic            Misaligned;
  logic            OutOfBounds;
  logic            AccessFault;

  int n_chk  = 0;
  int n_fail = 0;

  mem_stage_param #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .Valid          (Valid),
    .ALUResult      (ALUResult),
    .WriteData      (WriteData),
    .Funct3         (Funct3),
    .Rd             (Rd),
    .Zero           (Zero),
    .BranchTaken    (BranchTaken),
    .MemRead        (MemRead),
    .MemWrite       (MemWrite),
    .MemtoReg       (MemtoReg),
    .RegWrite       (RegWrite),
    .ReadData       (ReadData),
    .ALUResultOut   (ALUResultOut),
    .RdOut          (RdOut),
    .BranchTakenOut (BranchTakenOut),
    .MemtoRegOut    (MemtoRegOut),
    .RegWriteOut    (RegWriteOut),
    .ValidOut       (ValidOut),
    .Busy           (Busy),
    .Misaligned     (Misaligned),
    .OutOfBounds    (OutOfBounds),
    .AccessFault    (AccessFault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [63:0] a;
    logic [63:0] wd;
    logic [2:0]  f;
    logic        mr;
    logic        mw;
    logic [4:0]  rd;
    logic        bt;
    logic [63:0] er;
    logic [2:0]  eflg;  // {AccessFault, Misaligned, OutOfBounds}
  } vec_t;

  vec_t vq[$];
  logic [7:0] mb [BYTES];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic [63:0] a, input logic [63:0] wd,
                              input logic [2:0] f, input logic mr, input logic mw,
                              input logic [4:0] rd, input logic bt, input logic [63:0] er,
                              input logic [2:0] eflg);
    vec_t t;
    t.v = v; t.a = a; t.wd = wd; t.f = f; t.mr = mr; t.mw = mw;
    t.rd = rd; t.bt = bt; t.er = er; t.eflg = eflg;
    return t;
  endfunction

  task automatic drive(input vec_t t);
    Valid       = t.v;
    ALUResult   = t.a;
    WriteData   = t.wd;
    Funct3      = t.f;
    MemRead     = t.mr;
    MemWrite    = t.mw;
    Rd          = t.rd;
    BranchTaken = t.bt;
    MemtoReg    = t.mr;
    RegWrite    = t.mr | t.bt;
    Zero        = t.a[0];
  endtask

  // Apply one slot at a negedge, check its registered result at the next negedge.
  task automatic step(input vec_t t);
    drive(t);
    @(negedge clk);
    chk("rdata", ReadData, t.er);
    chk("flags", {61'd0, AccessFault, Misaligned, OutOfBounds}, {61'd0, t.eflg});
    chk("pass", {56'd0, ValidOut, BranchTakenOut, MemtoRegOut, RegWriteOut, RdOut},
        {56'd0, t.v, t.bt, t.mr, t.mr | t.bt, t.rd});
    chk("alu_out", ALUResultOut, t.a);
  endtask

  // Count cycles with Busy high starting from the current (release) negedge.
  task automatic count_busy(output int cnt);
    cnt = 0;
    while (Busy && cnt < 3000) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  // Reference model: byte-addressed memory, rules applied directly.
  task automatic model(input vec_t t, output logic [63:0] er, output logic [2:0] eflg);
    int          sz;
    logic        acc, af, ma, oob;
    logic [63:0] val;
    acc = t.v && (t.mr || t.mw);
    sz  = 1 << t.f[1:0];
    af = 1'b0; ma = 1'b0; oob = 1'b0; er = '0;
    if (acc) begin
      if (t.f == 3'd7 || (t.mw && t.f >= 3'd4)) af = 1'b1;
      else if ((t.a % sz) != 0)                 ma = 1'b1;
      else if (t.a >= 64'(BYTES))                oob = 1'b1;
    end
    if (acc && !af && !ma && !oob) begin
      if (t.mr && !t.mw) begin
        val = '0;
        for (int i = 0; i < sz; i++) val |= 64'(mb[t.a + 64'(i)]) << (8 * i);
        if (t.f < 3'd4 && sz < 8 && val[8*sz-1]) val |= ~((64'd1 << (8 * sz)) - 64'd1);
        er = val;
      end
      if (t.mw) begin
        for (int i = 0; i < sz; i++) mb[t.a + 64'(i)] = t.wd[8*i +: 8];
      end
    end
    eflg = {af, ma, oob};
  endtask

  initial begin
    int          cnt;
    vec_t        idle, t;
    logic [63:0] er;
    logic [2:0]  eflg;

    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(idle);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", {63'd0, Busy}, 64'd1);
    chk("reset_outs", {ReadData[31:0], 26'd0, ValidOut, AccessFault, Misaligned,
                       OutOfBounds, BranchTakenOut, RegWriteOut}, 64'd0);

    // Reset re-asserted part way through clearing restarts the full sweep.
    reset = 1'b1;
    repeat (100) @(negedge clk);
    #2 reset = 1'b0;
    #1 chk("reclear_busy", {63'd0, Busy}, 64'd1);
    @(negedge clk);
    reset = 1'b1;
    // Try an access during clearing; it must be ignored.
    drive(mk(1, 64'h10, 0, 3'd7, 1, 0, 5'd3, 1, 0, 0));
    count_busy(cnt);
    chk("busy_cycles", 64'(cnt), 64'd1024);
    chk("busy_ignored", {62'd0, ValidOut, AccessFault}, 64'd0);

    // Directed vectors.
    vq.push_back(mk(1, 64'h10, 0, 3'd3, 1, 0, 5'd1, 0, 64'h0, 3'b000));
    vq.push_back(mk(1, 64'h10, 64'hDEADBEEFDEADBEEF, 3'd3, 0, 1, 5'd0, 0, 64'h0, 3'b000));
    vq.push_back(mk(1, 64'h13, 0, 3'd0, 1, 0, 5'd2, 0, 64'hFFFFFFFFFFFFFFDE, 3'b000));
    vq.push_back(mk(1, 64'h13, 0, 3'd4, 1, 0, 5'd2, 0, 64'h00000000000000DE, 3'b000));
    vq.push_back(mk(1, 64'h14, 0, 3'd2, 1, 0, 5'd4, 0, 64'hFFFFFFFFDEADBEEF, 3'b000));
    vq.push_back(mk(1, 64'h14, 0, 3'd6, 1, 0, 5'd4, 0, 64'h00000000DEADBEEF, 3'b000));
    vq.push_back(mk(1, 64'h12, 64'h1234, 3'd1, 0, 1, 5'd0, 0, 64'h0, 3'b000));
    vq.push_back(mk(1, 64'h10, 0, 3'd3, 1, 0, 5'd5, 0, 64'hDEADBEEF1234BEEF, 3'b000));
    vq.push_back(mk(1, 64'h12, 0, 3'd1, 1, 0, 5'd5, 0, 64'h0000000000001234, 3'b000));
    vq.push_back(mk(1, 64'h16, 0, 3'd1, 1, 0, 5'd5, 0, 64'hFFFFFFFFFFFFDEAD, 3'b000));
    vq.push_back(mk(1, 64'h16, 0, 3'd5, 1, 0, 5'd5, 0, 64'h000000000000DEAD, 3'b000));
    vq.push_back(mk(1, 64'h12, 0, 3'd2, 1, 0, 5'd6, 0, 64'h0, 3'b010));
    vq.push_back(mk(1, 64'h11, 0, 3'd1, 1, 0, 5'd6, 0, 64'h0, 3'b010));
    vq.push_back(mk(1, 64'h14, 64'h0, 3'd3, 0, 1, 5'd0, 0, 64'h0, 3'b010));
    vq.push_back(mk(1, 64'h10, 0, 3'd3, 1, 0, 5'd7, 0, 64'hDEADBEEF1234BEEF, 3'b000));
    vq.push_back(mk(1, 64'h10, 0, 3'd7, 1, 0, 5'd7, 0, 64'h0, 3'b100));
    vq.push_back(mk(1, 64'h1FF8, 64'h5555555555555555, 3'd3, 0, 1, 5'd0, 0, 64'h0, 3'b000));
    vq.push_back(mk(1, 64'h1FF8, 0, 3'd3, 1, 0, 5'd8, 0, 64'h5555555555555555, 3'b000));
    vq.push_back(mk(1, 64'h2000, 0, 3'd3, 1, 0, 5'd13, 1, 64'h0, 3'b001));
    vq.push_back(mk(1, 64'h8000000000000010, 0, 3'd3, 1, 0, 5'd9, 0, 64'h0, 3'b001));
    vq.push_back(mk(1, 64'h2003, 0, 3'd7, 1, 0, 5'd9, 0, 64'h0, 3'b100));
    vq.push_back(mk(1, 64'h2002, 0, 3'd2, 1, 0, 5'd9, 0, 64'h0, 3'b010));
    vq.push_back(mk(1, 64'h18, 64'hFF, 3'd4, 0, 1, 5'd0, 0, 64'h0, 3'b100));
    vq.push_back(mk(1, 64'h18, 0, 3'd3, 1, 0, 5'd10, 0, 64'h0, 3'b000));
    vq.push_back(mk(1, 64'h20, 64'hAB, 3'd0, 1, 1, 5'd11, 0, 64'h0, 3'b000));
    vq.push_back(mk(1, 64'h20, 0, 3'd4, 1, 0, 5'd11, 0, 64'hAB, 3'b000));
    vq.push_back(mk(0, 64'h28, 64'h1234, 3'd3, 0, 1, 5'd12, 1, 64'h0, 3'b000));
    vq.push_back(mk(0, 64'h10, 0, 3'd7, 1, 0, 5'd12, 0, 64'h0, 3'b000));
    vq.push_back(mk(1, 64'h28, 0, 3'd3, 1, 0, 5'd12, 0, 64'h0, 3'b000));
    for (int i = 0; i < vq.size(); i++) step(vq[i]);

    // Reset pulse in the middle of normal operation.
    step(mk(1, 64'h10, 64'hFFFFFFFFFFFFFFFF, 3'd3, 0, 1, 5'd0, 0, 64'h0, 3'b000));
    step(mk(1, 64'h10, 0, 3'd3, 1, 0, 5'd14, 1, 64'hFFFFFFFFFFFFFFFF, 3'b000));
    #2 reset = 1'b0;
    #1 chk("async_clear", {ReadData[59:0], ValidOut, BranchTakenOut, Busy, AccessFault},
           {60'd0, 1'b0, 1'b0, 1'b1, 1'b0});
    @(negedge clk);
    reset = 1'b1;
    count_busy(cnt);
    chk("busy_cycles2", 64'(cnt), 64'd1024);
    step(mk(1, 64'h10, 0, 3'd3, 1, 0, 5'd15, 0, 64'h0, 3'b000));

    // Randomized traffic against the byte model; memory is all zero here.
    for (int i = 0; i < int'(BYTES); i++) mb[i] = 8'h00;
    for (int n = 0; n < 600; n++) begin
      int sel;
      sel    = $urandom_range(0, 9);
      t.v    = ($urandom_range(0, 7) != 0);
      if (sel <= 5)      t.a = 64'($urandom_range(0, 63));
      else if (sel <= 7) t.a = 64'h1FE0 + 64'($urandom_range(0, 31));
      else if (sel == 8) t.a = 64'h2000 + 64'($urandom_range(0, 15));
      else               t.a = {32'($urandom), 32'($urandom)};
      t.wd   = {32'($urandom), 32'($urandom)};
      t.f    = 3'($urandom_range(0, 7));
      t.mr   = 1'($urandom_range(0, 1));
      t.mw   = 1'($urandom_range(0, 1));
      t.rd   = 5'($urandom_range(0, 31));
      t.bt   = 1'($urandom_range(0, 1));
      model(t, er, eflg);
      t.er   = er;
      t.eflg = eflg;
      step(t);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage_param.md
MEM_STAGE_PARAM -- requirements
Module: mem_stage_param

Interface
Parameters:
REQ-001 SHALL provide parameter XLEN, default 64, data/address width; legal values are 32 and 64.
REQ-002 SHALL provide parameter DEPTH, default 1024, number of XLEN-bit words; power of two, minimum 16.
Ports:
REQ-003 SHALL provide clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL provide reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL provide Valid  input  1  access/pipeline slot present this cycle.
REQ-006 SHALL provide ALUResult  input  XLEN  byte address / pass-through value.
REQ-007 SHALL provide WriteData  input  XLEN  store data, LSB-aligned.
REQ-008 SHALL provide Funct3  input  3  RISC-V load/store size/sign code.
REQ-009 SHALL provide Rd  input  5; Zero, BranchTaken, MemRead, MemWrite, MemtoReg, RegWrite  inputs  1 each.
REQ-010 SHALL provide ReadData  output  XLEN  extended load result.
REQ-011 SHALL provide ALUResultOut XLEN, RdOut 5, BranchTakenOut, MemtoRegOut, RegWriteOut, ValidOut 1 each  outputs  registered pass-through.
REQ-012 SHALL provide Busy  output  1  memory clear in progress; inputs ignored.
REQ-013 SHALL provide Misaligned, OutOfBounds, AccessFault  outputs  1  registered per-access fault flags.

Function
REQ-014 SHALL implement FSM states CLEAR and RUN; reset forces CLEAR with clear pointer 0.
REQ-015 In CLEAR, SHALL write zero to word[ptr] each cycle and increment ptr; after ptr = DEPTH-1 is written, SHALL go to RUN; Busy=1 exactly DEPTH cycles after reset release.
REQ-016 While Busy=1, SHALL perform no user access and drive ValidOut=0 and all fault flags 0.
REQ-017 In RUN, an access SHALL occur only when Valid=1; Valid=0 SHALL yield ValidOut=0 and no memory change.
REQ-018 All outputs SHALL be registered: one cycle latency from sampled inputs to ReadData, pass-through outputs and flags.
REQ-019 Byte order SHALL be little-endian; word index = ALUResult >> log2(XLEN/8).
REQ-020 Funct3 SHALL map: 000 B signed, 001 H signed, 010 W signed, 011 D, 100 BU, 101 HU, 110 WU; stores use 000/001/010/011 only.
REQ-021 AccessFault SHALL assert for Funct3=111, for store Funct3>=100, and for 011/110 when XLEN=32.
REQ-022 Misaligned SHALL assert when ALUResult is not a multiple of access size.
REQ-023 OutOfBounds SHALL assert when word index >= DEPTH (all upper address bits checked).
REQ-024 On any fault: no write, ReadData=0; priority for flag reporting AccessFault > Misaligned > OutOfBounds, only one flag set.
REQ-025 Stores SHALL update only the addressed byte lanes; other bytes unchanged.
REQ-026 Loads SHALL sign- or zero-extend to XLEN per Funct3; ReadData=0 when MemRead=0.
REQ-027 MemRead and MemWrite both 1: write performed, ReadData=0.
REQ-028 Load in the cycle after a store to the same address SHALL return the new data.
REQ-029 Pass-through outputs SHALL equal the inputs sampled the previous edge, independent of faults.

Reset
REQ-030 Reset assertion SHALL immediately clear all outputs to 0, set Busy=1, FSM=CLEAR, ptr=0.
REQ-031 Reset during CLEAR or RUN SHALL restart clearing from word 0; memory contents after clear SHALL be all zero.

Verification (XLEN=64, DEPTH=1024)
REQ-032 Release reset -> Busy=1 for 1024 cycles then 0; LD @0x10 -> ReadData=0, no flags.
REQ-033 SD 0xDEADBEEFDEADBEEF @0x10; LB @0x13 -> 0xFFFFFFFFFFFFFFDE; LBU @0x13 -> 0xDE; LW @0x14 -> 0xFFFFFFFFDEADBEEF; LWU @0x14 -> 0x00000000DEADBEEF.
REQ-034 Then SH 0x1234 @0x12; LD @0x10 -> 0xDEADBEEF1234BEEF.
REQ-035 LW @0x12 -> Misaligned=1, ReadData=0; SD 0x0 @0x14 then LD @0x10 -> unchanged; Funct3=111 -> AccessFault=1.
REQ-036 SD 0x5555555555555555 @0x1FF8, LD @0x1FF8 -> same value; LD @0x2000 -> OutOfBounds=1, ReadData=0; BranchTaken=1 with Rd=13 -> BranchTakenOut=1, RdOut=13 next cycle.
REQ-037 SD 0xFFFFFFFFFFFFFFFF @0x10, pulse reset low mid-run, wait 1024 cycles -> LD @0x10 returns 0.
